// File: rtl/reg_bank_ba_if.sv
// reg_bank_ba_if - bus bundle for the reg_bank_ba register bank.
//
// Carries the write port, the two read ports (A: base-address port with
// optional R0 gating, B: plain) and the pending-write lock port.
// clk and clr are plain ports on the bank itself and are not part of this
// bundle.
//
// Signals:
//   we, waddr, wdata         write port
//   ra_en, raddr_a, BAout    port A request / address / base-address select
//   rb_en, raddr_b           port B request / address
//   lock_en, lock_addr       mark a register as pending-write
//   rdata_a, valid_a, stall_a  port A response (stall is combinational)
//   rdata_b, valid_b, stall_b  port B response (stall is combinational)
//
// Modports: master drives requests (control unit / bench), slave is the bank.
interface reg_bank_ba_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             ra_en;
    logic [AW-1:0]    raddr_a;
    logic             rb_en;
    logic [AW-1:0]    raddr_b;
    logic             BAout;
    logic             lock_en;
    logic [AW-1:0]    lock_addr;
    logic [WIDTH-1:0] rdata_a;
    logic             valid_a;
    logic             stall_a;
    logic [WIDTH-1:0] rdata_b;
    logic             valid_b;
    logic             stall_b;

    modport master (
        output we, waddr, wdata, ra_en, raddr_a, rb_en, raddr_b, BAout,
               lock_en, lock_addr,
        input  rdata_a, valid_a, stall_a, rdata_b, valid_b, stall_b
    );

    modport slave (
        input  we, waddr, wdata, ra_en, raddr_a, rb_en, raddr_b, BAout,
               lock_en, lock_addr,
        output rdata_a, valid_a, stall_a, rdata_b, valid_b, stall_b
    );
endinterface

// File: rtl/reg_bank_ba.sv
// reg_bank_ba - parametrised general-purpose register bank.
//
// One write port, two registered read ports with write-to-read forwarding,
// and a per-register pending-write lock.  Port A is the base-address port:
// with R0_GATE=1, reading address 0 while BAout=1 returns zero.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   clr   asynchronous active-low reset (clears registers, outputs, locks)
//   bus   reg_bank_ba_if.slave, see the interface for the signal list
//
// Read handshake (both ports): a request is accepted at a rising edge when
// rX_en=1 and stall_X=0; rdata_X/valid_X=1 appear right after that edge.
// A stalled request is dropped, so the requester keeps rX_en (and the
// address) asserted until it sees stall_X=0.  valid_X is a one-cycle pulse;
// rdata_X holds its last value when nothing is accepted.
module reg_bank_ba #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int R0_GATE = 1
) (
    input logic           clk,
    input logic           clr,
    reg_bank_ba_if.slave  bus
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] lock;

    // Per-port lookup results.  hit_X is 0 for addresses >= DEPTH, which
    // is how out-of-range reads return zero and never see a lock.
    logic [WIDTH-1:0] old_a, old_b;
    logic             hit_a, hit_b;
    logic             lk_a, lk_b;
    logic             fwd_a, fwd_b;
    logic             gate_a;
    logic [WIDTH-1:0] next_a, next_b;

    always_comb begin
        old_a = '0;
        old_b = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        lk_a  = 1'b0;
        lk_b  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) begin
                old_a = mem[i];
                hit_a = 1'b1;
                lk_a  = lock[i];
            end
            if (bus.raddr_b == AW'(i)) begin
                old_b = mem[i];
                hit_b = 1'b1;
                lk_b  = lock[i];
            end
        end
    end

    // A write to the same address in this cycle both forwards its data and
    // releases a pending lock on that read.
    assign fwd_a  = bus.we && (bus.waddr == bus.raddr_a);
    assign fwd_b  = bus.we && (bus.waddr == bus.raddr_b);
    assign gate_a = (R0_GATE != 0) && bus.BAout && (bus.raddr_a == '0);

    // A gated R0 read never depends on register content, so it never stalls.
    assign bus.stall_a = bus.ra_en && lk_a && !fwd_a && !gate_a;
    assign bus.stall_b = bus.rb_en && lk_b && !fwd_b;

    // Gating overrides everything; out-of-range reads return zero even if
    // an ignored write targets the same address.
    always_comb begin
        next_a = old_a;
        if (gate_a || !hit_a) begin
            next_a = '0;
        end else if (fwd_a) begin
            next_a = bus.wdata;
        end
    end

    always_comb begin
        next_b = old_b;
        if (!hit_b) begin
            next_b = '0;
        end else if (fwd_b) begin
            next_b = bus.wdata;
        end
    end

    // Register file and lock bits.  A lock landing on the same register as
    // a write wins over the write's lock clear; the data is still written.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            lock <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.we && (bus.waddr == AW'(i))) begin
                    mem[i] <= bus.wdata;
                end
                if (bus.lock_en && (bus.lock_addr == AW'(i))) begin
                    lock[i] <= 1'b1;
                end else if (bus.we && (bus.waddr == AW'(i))) begin
                    lock[i] <= 1'b0;
                end
            end
        end
    end

    // Read port registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.rdata_a <= '0;
            bus.valid_a <= 1'b0;
            bus.rdata_b <= '0;
            bus.valid_b <= 1'b0;
        end else begin
            bus.valid_a <= 1'b0;
            bus.valid_b <= 1'b0;
            if (bus.ra_en && !bus.stall_a) begin
                bus.rdata_a <= next_a;
                bus.valid_a <= 1'b1;
            end
            if (bus.rb_en && !bus.stall_b) begin
                bus.rdata_b <= next_b;
                bus.valid_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_ba.sv
// tb_reg_bank_ba - directed, table-driven bench for reg_bank_ba (DEPTH=12).
module tb_reg_bank_ba;

    localparam int W  = 32;
    localparam int AW = 4;

    logic clk;
    logic clr;

    reg_bank_ba_if #(.WIDTH(W), .AW(AW)) bus ();

    reg_bank_ba #(
        .WIDTH  (W),
        .DEPTH  (12),
        .AW     (AW),
        .R0_GATE(1)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic          ra_en;
        logic [AW-1:0] raddr_a;
        logic          ba;
        logic          rb_en;
        logic [AW-1:0] raddr_b;
        logic          lock_en;
        logic [AW-1:0] lock_addr;
        logic          exp_stall_a;
        logic          exp_stall_b;
        logic          exp_valid_a;
        logic [W-1:0]  exp_rdata_a;
        logic          exp_valid_b;
        logic [W-1:0]  exp_rdata_b;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check1(input string name, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.we        = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.ra_en     = 1'b0;
        bus.raddr_a   = '0;
        bus.BAout     = 1'b0;
        bus.rb_en     = 1'b0;
        bus.raddr_b   = '0;
        bus.lock_en   = 1'b0;
        bus.lock_addr = '0;
    endtask

    // Drive at the falling edge, check stalls just after, clock the rising
    // edge, then check the registered outputs 1 time unit after it.
    task automatic apply(input vec_t v);
        logic [W-1:0] ea, eb;
        @(negedge clk);
        bus.we        = v.we;
        bus.waddr     = v.waddr;
        bus.wdata     = v.wdata;
        bus.ra_en     = v.ra_en;
        bus.raddr_a   = v.raddr_a;
        bus.BAout     = v.ba;
        bus.rb_en     = v.rb_en;
        bus.raddr_b   = v.raddr_b;
        bus.lock_en   = v.lock_en;
        bus.lock_addr = v.lock_addr;
        exp_q.push_back(v.exp_rdata_a);
        exp_q.push_back(v.exp_rdata_b);
        #1;
        check1({v.name, ".stall_a"}, W'(bus.stall_a), W'(v.exp_stall_a));
        check1({v.name, ".stall_b"}, W'(bus.stall_b), W'(v.exp_stall_b));
        @(posedge clk);
        #1;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        check1({v.name, ".valid_a"}, W'(bus.valid_a), W'(v.exp_valid_a));
        check1({v.name, ".rdata_a"}, bus.rdata_a, ea);
        check1({v.name, ".valid_b"}, W'(bus.valid_b), W'(v.exp_valid_b));
        check1({v.name, ".rdata_b"}, bus.rdata_b, eb);
    endtask

    function automatic vec_t mk(
        input string name,
        input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
        input logic rae, input logic [AW-1:0] ra, input logic ba,
        input logic rbe, input logic [AW-1:0] rb,
        input logic le, input logic [AW-1:0] la,
        input logic sa, input logic sb,
        input logic va, input logic [W-1:0] da,
        input logic vb, input logic [W-1:0] db);
        vec_t v;
        v.name = name;
        v.we = we; v.waddr = wa; v.wdata = wd;
        v.ra_en = rae; v.raddr_a = ra; v.ba = ba;
        v.rb_en = rbe; v.raddr_b = rb;
        v.lock_en = le; v.lock_addr = la;
        v.exp_stall_a = sa; v.exp_stall_b = sb;
        v.exp_valid_a = va; v.exp_rdata_a = da;
        v.exp_valid_b = vb; v.exp_rdata_b = db;
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        //               name             we wa  wdata         rae ra  ba rbe rb  le la  sa sb va rdata_a       vb rdata_b
        vecs.push_back(mk("fwd_r3",        1, 3, 32'h0000_1234, 1, 3,  0, 0, 0,  0, 0,  0, 0, 1, 32'h0000_1234, 0, 32'h0));
        vecs.push_back(mk("rd_b_r3",       0, 0, 32'h0,         0, 0,  0, 1, 3,  0, 0,  0, 0, 0, 32'h0000_1234, 1, 32'h0000_1234));
        vecs.push_back(mk("wr_r0",         1, 0, 32'hAAAA_5555, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 32'h0000_1234, 0, 32'h0000_1234));
        vecs.push_back(mk("r0_gate_a",     0, 0, 32'h0,         1, 0,  1, 1, 0,  0, 0,  0, 0, 1, 32'h0,         1, 32'hAAAA_5555));
        vecs.push_back(mk("r0_nogate_a",   0, 0, 32'h0,         1, 0,  0, 0, 0,  0, 0,  0, 0, 1, 32'hAAAA_5555, 0, 32'hAAAA_5555));
        vecs.push_back(mk("gate_over_fwd", 1, 0, 32'h0000_1111, 1, 0,  1, 1, 0,  0, 0,  0, 0, 1, 32'h0,         1, 32'h0000_1111));
        vecs.push_back(mk("lock_r7",       0, 0, 32'h0,         0, 0,  0, 0, 0,  1, 7,  0, 0, 0, 32'h0,         0, 32'h0000_1111));
        vecs.push_back(mk("stall_r7",      0, 0, 32'h0,         1, 7,  0, 1, 7,  0, 0,  1, 1, 0, 32'h0,         0, 32'h0000_1111));
        vecs.push_back(mk("stall_r7_hold", 0, 0, 32'h0,         1, 7,  0, 1, 7,  0, 0,  1, 1, 0, 32'h0,         0, 32'h0000_1111));
        vecs.push_back(mk("release_r7",    1, 7, 32'h0000_0077, 1, 7,  0, 1, 7,  0, 0,  0, 0, 1, 32'h0000_0077, 1, 32'h0000_0077));
        vecs.push_back(mk("unlocked_r7",   0, 0, 32'h0,         1, 7,  0, 0, 0,  0, 0,  0, 0, 1, 32'h0000_0077, 0, 32'h0000_0077));
        vecs.push_back(mk("lock_wr_r9",    1, 9, 32'h0000_0099, 0, 0,  0, 0, 0,  1, 9,  0, 0, 0, 32'h0000_0077, 0, 32'h0000_0077));
        vecs.push_back(mk("r9_stalls",     0, 0, 32'h0,         1, 9,  0, 0, 0,  0, 0,  1, 0, 0, 32'h0000_0077, 0, 32'h0000_0077));
        vecs.push_back(mk("wr_oor_rd_oor", 1,13, 32'hFFFF_FFFF, 0, 0,  0, 1,13,  0, 0,  0, 0, 0, 32'h0000_0077, 1, 32'h0));
        vecs.push_back(mk("no_alias",      0, 0, 32'h0,         1, 3,  0, 1, 1,  0, 0,  0, 0, 1, 32'h0000_1234, 1, 32'h0));
        vecs.push_back(mk("last_reg",      1,11, 32'h0000_BBBB, 1,11,  0, 1,12,  0, 0,  0, 0, 1, 32'h0000_BBBB, 1, 32'h0));
        vecs.push_back(mk("same_addr",     0, 0, 32'h0,         1,11,  0, 1,11,  0, 0,  0, 0, 1, 32'h0000_BBBB, 1, 32'h0000_BBBB));
        vecs.push_back(mk("release_r9",    1, 9, 32'h0000_9999, 1, 9,  0, 1, 9,  0, 0,  0, 0, 1, 32'h0000_9999, 1, 32'h0000_9999));
        vecs.push_back(mk("lock_oor",      0, 0, 32'h0,         1,14,  0, 0, 0,  1,14,  0, 0, 1, 32'h0,         0, 32'h0000_9999));
        vecs.push_back(mk("rd_oor_lkd",    0, 0, 32'h0,         1,14,  0, 1,14,  0, 0,  0, 0, 1, 32'h0,         1, 32'h0));
        vecs.push_back(mk("lock_r0",       0, 0, 32'h0,         1, 3,  0, 0, 0,  1, 0,  0, 0, 1, 32'h0000_1234, 0, 32'h0));
        vecs.push_back(mk("r0_gate_nost",  0, 0, 32'h0,         1, 0,  1, 0, 0,  0, 0,  0, 0, 1, 32'h0,         0, 32'h0));
        vecs.push_back(mk("r0_lock_stall", 0, 0, 32'h0,         1, 0,  0, 1, 0,  0, 0,  1, 1, 0, 32'h0,         0, 32'h0));

        drive_idle();
        clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;

        // Reset state after release.
        #1;
        check1("reset.rdata_a", bus.rdata_a, '0);
        check1("reset.valid_a", W'(bus.valid_a), '0);
        check1("reset.rdata_b", bus.rdata_b, '0);

        // Asynchronous clear in mid-cycle: write R5 and read it so outputs
        // are non-zero, then drop clr between edges.
        apply(mk("wr_r5", 1, 5, 32'hDEAD_BEEF, 1, 5, 0, 1, 5, 0, 0,
                 0, 0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF));
        drive_idle();
        #2;
        clr = 1'b0;
        #1;
        check1("async_clr.rdata_a", bus.rdata_a, '0);
        check1("async_clr.valid_a", W'(bus.valid_a), '0);
        check1("async_clr.rdata_b", bus.rdata_b, '0);
        check1("async_clr.valid_b", W'(bus.valid_b), '0);
        @(negedge clk);
        clr = 1'b1;
        apply(mk("r5_after_clr", 0, 0, 32'h0, 1, 5, 0, 0, 0, 0, 0,
                 0, 0, 1, 32'h0, 0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_ba.md
Name: reg_bank_ba

Overview:
- Parametrised general-purpose register bank; the successor to the single 32-bit enable/clear register.
- Replaces per-register instances in the datapath with one block that has one write port, two registered read ports and write-to-read forwarding.
- Port A is the base-address read port. R0 reads as zero on port A when BAout is asserted.
- A per-register pending-write lock lets the control unit hold back reads of registers awaiting a result.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 16, number of registers (2..2**AW)
AW, 4, address width
R0_GATE, 1, 1 = port A returns zero for address 0 while BAout=1; 0 = no gating

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  asynchronous, active-low reset
we  input  1  write enable
waddr  input  AW  write address
wdata  input  WIDTH  write data
ra_en  input  1  port A read request
raddr_a  input  AW  port A address
rb_en  input  1  port B read request
raddr_b  input  AW  port B address
BAout  input  1  base-address select (active-high), applies to port A only
lock_en  input  1  mark a register as pending-write
lock_addr  input  AW  register to lock
rdata_a  output  WIDTH  port A data, registered
valid_a  output  1  rdata_a updated this cycle
stall_a  output  1  combinational: port A request blocked by lock
rdata_b  output  WIDTH  port B data, registered
valid_b  output  1  rdata_b updated this cycle
stall_b  output  1  combinational: port B request blocked by lock

Behaviour:

Reset:
- clr=0 immediately forces all registers, rdata_a, rdata_b, valid_a, valid_b and all lock bits to 0, independent of clk.
- On release, the first rising edge with clr=1 operates normally.

Write:
- At posedge, we=1 with waddr<DEPTH: reg[waddr]<=wdata and lock[waddr]<=0.
- waddr>=DEPTH: write ignored.
- R0 is writable; gating affects only port A reads.

Reads (identical for A and B, port X):
- Request at posedge N (rX_en=1, stall_X=0): rdata_X and valid_X=1 appear after edge N; 1-cycle latency.
- No request or stalled: valid_X=0 and rdata_X holds its previous value.
- Forwarding: if we=1 and waddr==raddr_X at the same edge, rdata_X<=wdata, not the old content.
- raddr_X>=DEPTH: rdata_X<=0, valid_X=1.
- R0_GATE=1, raddr_a==0, BAout=1 at the edge: rdata_a<=0, overriding both forwarding and reg[0]. Port B is never gated.

Lock / scoreboard:
- At posedge, lock_en=1 with lock_addr<DEPTH: lock[lock_addr]<=1.
- Same edge, same address as a write: the lock is set; lock has priority over the write's clear, and the data is still written.
- stall_X = rX_en & lock[raddr_X] & ~(we & waddr==raddr_X).
- A write arriving in the same cycle as a locked read releases the stall; the read then completes with forwarded wdata.
- Address-0 read on port A with R0 gating active never stalls.
- Stalled requests are dropped; the requester must hold rX_en until stall_X=0.

Simultaneous events:
- Both ports may read the same address in the same cycle; both return the same data.
- A lock, a write and two reads may all occur in one cycle; the rules above apply independently.

Test Plan:
- Reset: write 0xDEADBEEF to R5, assert clr=0 mid-cycle -> all outputs 0 asynchronously; after release, read R5 on A -> rdata_a=0, valid_a=1 one cycle later.
- Latency/forward: write R3=0x1234 at edge N with ra_en, raddr_a=3 at N -> rdata_a=0x1234 after N. Read R3 on B at N+1 -> rdata_b=0x1234, valid_b=1.
- R0 gating: write R0=0xAAAA_5555. Read R0 on A with BAout=1 -> 0. Read R0 on A with BAout=0 -> 0xAAAA5555. Read R0 on B with BAout=1 -> 0xAAAA5555.
- Lock: lock R7, then ra_en raddr_a=7 -> stall_a=1, valid_a=0, rdata_a unchanged. Write R7=0x77 in a later cycle with the read held -> stall_a=0 that cycle, rdata_a=0x77 next.
- Lock/write collision: lock_en and we both on R9 with wdata=0x99 -> R9=0x99 and lock[9]=1. Subsequent read of R9 stalls.
- Range (DEPTH=12): write addr 13 -> no register changes. Read addr 13 -> rdata=0, valid=1.
